uart_byte_tx: RTL and testbench

//   Byte-to-serial UART transmitter with a small input FIFO; consumes the bytes

---
 rtl/uart_byte_tx.sv | 131 +++++++++++++
 tb/tb_uart_byte_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a small input FIFO. The upstream side sees only a
// valid/ready handshake, and it never has to wait for the baud rate while the FIFO has room.
module uart_byte_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic             fifo_empty, fifo_full, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && !fifo_full;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_mem[rd_ptr_reg[AW-1:0]];
          baud_cnt_next = '0;
          state_next    = START;
        end
      end
      START: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg[AW-1:0]];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_reg)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift_reg[0];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized bench for uart_byte_tx: a line monitor decodes frames, and each test
// compares them to the bytes it handed over and to frame timing derived from 10 cycles per bit.
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, busy;
  logic [2:0] fifo_level;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  // Line monitor: decodes frames by sampling mid-bit and records each byte with its start cycle.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_ok[$];
  bit         mon_active = 1'b0;
  bit         mon_ok;
  int         mon_cnt, mon_start;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_start  = cyc;
        mon_ok     = 1'b1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5 && uart_tx !== 1'b0) mon_ok = 1'b0;
      if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
        mon_byte[(mon_cnt - 15) / 10] = uart_tx;
      if (mon_cnt == 95) begin
        rx_q.push_back(mon_byte);
        rx_t.push_back(mon_start);
        rx_ok.push_back(mon_ok && (uart_tx === 1'b1));
      end
      if (mon_cnt == 99) mon_active = 1'b0;
    end
  end

  // Expected line level k cycles after a frame's start: start 0, 8 data bits LSB first, stop 1.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int slot;
    slot = k / 10;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL push_timeout byte=%02h: tx_ready stuck at %b, required 1 within 500 cycles", b, tx_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0 within 2000 cycles", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int guard;
    guard = 0;
    while (rx_q.size() < n && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL frame_timeout: decoded %0d frames, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_uart_tx: got %b, want 1", uart_tx); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b, want 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, want 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d, want 0", fifo_level); end
    #1 rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL idle_after_reset: %0d bad cycles, want 0", bad); end
    end
    $display("test_reset: done");
  endtask

  task automatic test_single(input logic [7:0] b);
    int acc, base, bad;
    base = rx_q.size();
    push_byte(b, acc);
    drop_valid();
    n_cmp++; if (fifo_level !== 3'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: level=%0d busy=%b, want level=1 busy=1", fifo_level, busy);
    end
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: uart_tx=%b at accept cycle, want 1", uart_tx); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      wait_to(acc + 1 + k);
      if (uart_tx !== exp_line(b, k)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL single_line byte=%02h: %0d cycles wrong, want 0", b, bad); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop: busy=%b on last stop cycle, want 1", busy); end
    wait_to(acc + 101);
    n_cmp++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_fall: busy=%b uart_tx=%b at N+101, want 0/1", busy, uart_tx);
    end
    wait_frames(base + 1, 50);
    if (rx_q.size() > base) begin
      n_cmp++; if (rx_q[base] !== b || rx_t[base] != acc + 1 || !rx_ok[base]) begin
        n_fail++; $display("FAIL single_decode: byte=%02h start=%0d ok=%0b, want byte=%02h start=%0d ok=1",
                           rx_q[base], rx_t[base], rx_ok[base], b, acc + 1);
      end
    end
    $display("test_single: byte=%02h accepted at %0d", b, acc);
  endtask

  task automatic test_burst();
    int acc[6];
    int base;
    logic [7:0] b;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      push_byte(b, acc[i]);
    end
    @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd4 || tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL burst_full: level=%0d tx_ready=%b, want 4/0", fifo_level, tx_ready);
    end
    push_byte(8'h15, acc[5]);
    drop_valid();
    n_cmp++; if (acc[5] != acc[0] + 102) begin
      n_fail++; $display("FAIL burst_late_accept: 0x15 accepted at %0d, want %0d", acc[5], acc[0] + 102);
    end
    wait_frames(base + 6, 800);
    for (int i = 0; i < 6; i++) begin
      if (rx_q.size() > base + i) begin
        n_cmp++;
        if (rx_q[base+i] !== 8'h10 + 8'(i) || rx_t[base+i] != acc[0] + 1 + 100 * i || !rx_ok[base+i]) begin
          n_fail++; $display("FAIL burst_frame%0d: byte=%02h start=%0d ok=%0b, want byte=%02h start=%0d ok=1",
                             i, rx_q[base+i], rx_t[base+i], rx_ok[base+i], 8'h10 + 8'(i), acc[0] + 1 + 100 * i);
        end
      end
    end
    $display("test_burst: 6 bytes, first accepted at %0d", acc[0]);
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, s, bad, base;
    base = rx_q.size();
    push_byte(8'h00, acc0);
    push_byte(8'hFF, acc1);
    drop_valid();
    s = acc0 + 1;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      wait_to(s + k);
      if (busy !== 1'b1) bad++;
      if (uart_tx !== ((k < 100) ? exp_line(8'h00, k) : exp_line(8'hFF, k - 100))) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL b2b_line: %0d bad cycles over 200, want 0", bad); end
    wait_to(s + 200);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall: busy=%b at start+200, want 0", busy); end
    wait_frames(base + 2, 50);
    if (rx_q.size() >= base + 2) begin
      n_cmp++; if (rx_q[base] !== 8'h00 || rx_q[base+1] !== 8'hFF || rx_t[base+1] - rx_t[base] != 100) begin
        n_fail++; $display("FAIL b2b_decode: %02h,%02h gap=%0d, want 00,FF gap=100",
                           rx_q[base], rx_q[base+1], rx_t[base+1] - rx_t[base]);
      end
    end
    $display("test_back_to_back: frames start at %0d", s);
  endtask

  task automatic test_reset_mid();
    int acc[3];
    int s, base, bad;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      if (i == 0) b = b & 8'hF7;
      push_byte(b, acc[i]);
    end
    drop_valid();
    s = acc[0] + 1;
    wait_to(s + 44);
    n_cmp++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_bit3: uart_tx=%b in data bit 3, want 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_async_tx: uart_tx=%b before any edge, want 1", uart_tx); end
    n_cmp++; if (fifo_level !== 3'd0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: level=%0d busy=%b ready=%b, want 0/0/1", fifo_level, busy, tx_ready);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    base = rx_q.size();
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0 || rx_q.size() != base) begin
      n_fail++; $display("FAIL midrst_quiet: %0d bad cycles, %0d new frames, want 0/0", bad, rx_q.size() - base);
    end
    $display("test_reset_mid: reset at cycle %0d", s + 44);
  endtask

  task automatic test_full_toggle();
    logic [7:0] exp_b[$];
    logic [7:0] b;
    int acc, base, extra, guard;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      push_byte(b, acc);
      exp_b.push_back(b);
    end
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL toggle_full: tx_ready=%b, want 0", tx_ready); end
    extra = 0;
    guard = 0;
    while (extra < 3 && guard < 1000) begin
      tx_data = 8'($urandom);
      if (tx_ready === 1'b1) begin
        exp_b.push_back(tx_data);
        extra++;
      end
      guard++;
      if (extra < 3) @(negedge clk);
    end
    drop_valid();
    n_cmp++; if (extra != 3) begin n_fail++; $display("FAIL toggle_accepts: %0d extra bytes accepted, want 3", extra); end
    wait_frames(base + exp_b.size(), 1200);
    for (int i = 0; i < exp_b.size(); i++) begin
      if (rx_q.size() > base + i) begin
        n_cmp++; if (rx_q[base+i] !== exp_b[i] || !rx_ok[base+i]) begin
          n_fail++; $display("FAIL toggle_frame%0d: byte=%02h ok=%0b, want %02h ok=1",
                             i, rx_q[base+i], rx_ok[base+i], exp_b[i]);
        end
      end
    end
    $display("test_full_toggle: %0d bytes sent", exp_b.size());
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      test_single(8'($urandom));
      wait_idle();
    end
    test_burst();
    wait_idle();
    test_back_to_back();
    wait_idle();
    test_reset_mid();
    test_full_toggle();
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
